inst_mem_loader: RTL

- Writer side of the instruction memory that the fetch path (PC register, PC mux, instruction memory) reads from.
- Receives a framed byte stream, assembles 32-bit little-endian instruction words, and writes them into the instruction memory write port.
- Holds the core in reset via `cpu_hold` until a complete, checksum-valid image has been written.

---
 rtl/inst_mem_loader.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/inst_mem_loader.sv
// Instruction memory loader: receives a framed byte stream (sync, 16-bit word
// count, little-endian words, XOR checksum), writes the words into the
// instruction memory and holds the core in reset until a valid image is loaded.
module inst_mem_loader #(
  parameter int          CPU_WIDTH  = 32,
  parameter int          ADDR_WIDTH = 8,
  parameter int          DEPTH      = 256,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [CPU_WIDTH-1:0]  mem_wdata,
  input  logic                  mem_wr_ready,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CNT_LO = 3'd1;
  localparam logic [2:0] S_CNT_HI = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_CHK    = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam logic [2:0] S_ERR    = 3'd7;

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  logic [2:0]  state;
  logic [7:0]  cnt_lo;
  logic [15:0] count;
  logic [15:0] wcnt;
  logic [15:0] wcnt_nx;
  logic [15:0] count_in;
  logic [1:0]  idx;
  logic [7:0]  chk_acc;
  logic        rx_fire;

  // Byte acceptance: blocked while writing a word and while reset is asserted.
  always_comb begin
    rx_ready = ~rst & (state != S_WRITE);
    rx_fire  = rx_valid & rx_ready;
    count_in = {rx_data, cnt_lo};
    wcnt_nx  = wcnt + 16'd1;
  end

  // Frame parser, word assembly and memory write handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt_lo    <= '0;
      count     <= '0;
      wcnt      <= '0;
      idx       <= '0;
      chk_acc   <= '0;
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      case (state)
        // IDLE, DONE and ERR share restart handling; any non-sync byte is dropped.
        S_IDLE, S_DONE, S_ERR: begin
          if (rx_fire && rx_data == SYNC_BYTE) begin
            state     <= S_CNT_LO;
            chk_acc   <= '0;
            idx       <= '0;
            wcnt      <= '0;
            mem_waddr <= '0;
            load_err  <= 1'b0;
            load_done <= 1'b0;
            cpu_hold  <= 1'b1;
          end
        end
        S_CNT_LO: begin
          if (rx_fire) begin
            cnt_lo <= rx_data;
            state  <= S_CNT_HI;
          end
        end
        S_CNT_HI: begin
          if (rx_fire) begin
            count <= count_in;
            if ({1'b0, count_in} > DEPTH_L) begin
              state    <= S_ERR;
              load_err <= 1'b1;
            end else if (count_in == '0) begin
              state <= S_CHK;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (rx_fire) begin
            mem_wdata[{idx, 3'b000} +: 8] <= rx_data;
            chk_acc <= chk_acc ^ rx_data;
            idx     <= idx + 2'd1;
            if (idx == 2'd3) begin
              state  <= S_WRITE;
              mem_we <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (mem_wr_ready) begin
            mem_we <= 1'b0;
            wcnt   <= wcnt_nx;
            if (wcnt_nx == count) begin
              state <= S_CHK;
            end else begin
              mem_waddr <= mem_waddr + ADDR_WIDTH'(1);
              state     <= S_DATA;
            end
          end
        end
        S_CHK: begin
          if (rx_fire) begin
            if (rx_data == chk_acc) begin
              state     <= S_DONE;
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
            end else begin
              state    <= S_ERR;
              load_err <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
